mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer sharing one 8:1 bit mux among 8 requesters.
//  Requester k owns data input din[k] and asserts req[k] to get the mux.
//  The block grants one requester at a time and drives the mux selects
//  {s0,s1,s2} = k, with s0 as MSB. It also registers the selected data bit
//  on out. A per-grant hold limit stops any requester from starving others.
// PARAMETERS
//  HOLD_MAX  4  max consecutive cycles per grant (>=1); counter width $clog2(HOLD_MAX+1)
// PORTS
//  clk     in   1  single clock, rising edge
//  rst_n   in   1  asynchronous active-low reset
//  req     in   8  request vector, bit k = requester k (level, held while wanted)
//  din     in   8  data inputs i0..i7, din[k] = ik
//  gnt     out  8  one-hot grant, registered
//  busy    out  1  1 while any grant is active
//  s0      out  1  select MSB   ({s0,s1,s2} = granted index)
//  s1      out  1  select mid
//  s2      out  1  select LSB
//  out     out  1  registered din[{s0,s1,s2}] while busy, else 0
// BEHAVIOUR
//  Reset (async, immediate, also mid-grant): gnt=0, busy=0, s0=s1=s2=0, out=0,
//   ptr=0, hold_cnt=0, state=IDLE.
//  State IDLE:
//   - If req==0, stay in IDLE.
//   - Else pick the first set req bit scanning ptr, ptr+1, ... mod 8 (ptr inclusive).
//   - On the next edge: gnt=onehot(k), {s0,s1,s2}=k, busy=1, hold_cnt=1, state=GRANT.
//   - Latency from req to gnt is 1 clk.
//  State GRANT (index g):
//   - Each cycle, out <= din[g]. out is 1 clk behind din and is first valid the
//     cycle after gnt rises.
//   - Release when req[g]==0 is sampled, or when hold_cnt==HOLD_MAX.
//   - If neither holds, hold_cnt++.
//   - On release: ptr <= (g+1) mod 8 (7 wraps to 0). Same-edge re-arbitration uses
//     the current req and the new ptr:
//      - Winner found: new grant, hold_cnt=1, stay in GRANT. No idle bubble.
//        A timed-out g whose req is still high is eligible, at lowest priority.
//        If g is the only requester it is re-granted back-to-back and gnt is unchanged.
//      - No winner: gnt=0, busy=0, out=0 on that edge, state=IDLE. s0..s2 hold the
//        last value.
//   - Requests arriving mid-grant are only considered at release.
//  Invariants: gnt is one-hot or zero; busy==|gnt; {s0,s1,s2}==index(gnt) when busy.
//  HOLD_MAX=1 gives one cycle per grant, i.e. round-robin every cycle.
// TESTING
//  1 Reset: rst_n=0 with req=FF, din=FF -> all outputs 0; rst_n=1 -> gnt=01 one clk later.
//  2 Single: req=08 for 2 clks then 00, din=08 -> gnt=08 and {s0,s1,s2}=011 after 1 clk;
//    out=1 the next clk; gnt=00, busy=0 the edge after req drop is sampled.
//  3 Fairness: req=FF held, HOLD_MAX=4 -> gnt walks 01,02,04,...,80,01, 4 clks each,
//    no gaps.
//  4 Wrap: after a grant to 1 (ptr=2), req=81 -> gnt=80 then 01; {s0,s1,s2}=111 then 000.
//  5 Timeout, sole requester: req=20 held 10 clks -> gnt=20 throughout, no idle cycle;
//    hold_cnt restarts every 4 clks.
//  6 Reset mid-grant: assert rst_n=0 asynchronously during gnt=10 -> outputs 0 at once;
//    after release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mux8_rr_arbiter
//  Description : Round-robin arbiter sharing one 8:1 bit mux among eight
//                requesters. Drives the mux selects {s0,s1,s2} with the
//                granted index and registers the selected data bit on out.
//                A per-grant hold limit bounds how long one requester keeps
//                the mux.
//  Revision    : 1.0 - initial release
// ============================================================================
module mux8_rr_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       out
);

    localparam int                 c_cnt_w    = $clog2(HOLD_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_hold_max = c_cnt_w'(HOLD_MAX);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state,    w_state_nxt;
    logic [7:0]         r_gnt,      w_gnt_nxt;
    logic [2:0]         r_sel,      w_sel_nxt;
    logic               r_busy,     w_busy_nxt;
    logic               r_out,      w_out_nxt;
    logic [2:0]         r_ptr,      w_ptr_nxt;
    logic [c_cnt_w-1:0] r_hold_cnt, w_hold_nxt;

    // Scan start: the stored pointer when idle, the slot after the current
    // owner when granting (that is what ptr becomes on release, so the
    // same-edge re-arbitration already sees the advanced pointer).
    logic [2:0] w_base;
    logic       w_found;
    logic [2:0] w_win;
    logic       w_release;

    assign w_base    = (r_state == ST_GRANT) ? (r_sel + 3'd1) : r_ptr;
    assign w_release = ~req[r_sel] | (r_hold_cnt == c_hold_max);

    // Rotating priority search: first set request at or after w_base, mod 8.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req[w_base + 3'(i)]) begin
                w_found = 1'b1;
                w_win   = w_base + 3'(i);
            end
        end
    end

    // Next-state and next-output logic; everything holds unless changed.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_busy_nxt  = r_busy;
        w_out_nxt   = r_out;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ST_IDLE: begin
                w_out_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = 8'b1 << w_win;
                    w_sel_nxt   = w_win;
                    w_busy_nxt  = 1'b1;
                    w_hold_nxt  = c_cnt_one;
                end
            end
            ST_GRANT: begin
                w_out_nxt = din[r_sel];
                if (w_release) begin
                    w_ptr_nxt = r_sel + 3'd1;
                    if (w_found) begin
                        // Back-to-back handover, no idle bubble.
                        w_gnt_nxt  = 8'b1 << w_win;
                        w_sel_nxt  = w_win;
                        w_hold_nxt = c_cnt_one;
                    end else begin
                        // Selects keep the last index while idle.
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = 8'd0;
                        w_busy_nxt  = 1'b0;
                        w_out_nxt   = 1'b0;
                    end
                end else begin
                    w_hold_nxt = r_hold_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 8'd0;
            r_sel      <= 3'd0;
            r_busy     <= 1'b0;
            r_out      <= 1'b0;
            r_ptr      <= 3'd0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_sel      <= w_sel_nxt;
            r_busy     <= w_busy_nxt;
            r_out      <= w_out_nxt;
            r_ptr      <= w_ptr_nxt;
            r_hold_cnt <= w_hold_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign busy = r_busy;
    assign s0   = r_sel[2];
    assign s1   = r_sel[1];
    assign s2   = r_sel[0];
    assign out  = r_out;

endmodule
`default_nettype wire

// File: tb/tb_mux8_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mux8_rr_arbiter
//  Description : Self-checking bench for mux8_rr_arbiter: directed scenarios
//                followed by random traffic, compared against a cycle-level
//                behavioural model of the arbitration rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mux8_rr_arbiter;

    localparam int HOLD_MAX = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic       busy;
    logic       s0, s1, s2, out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model state, in plain integers.
    int m_busy;
    int m_g;
    int m_ptr;
    int m_cnt;
    int m_out;

    mux8_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .din  (din),
        .gnt  (gnt),
        .busy (busy),
        .s0   (s0),
        .s1   (s1),
        .s2   (s2),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // First requester at or after position p, walking upward mod 8; -1 if none.
    function automatic int scan(input logic [7:0] r, input int p);
        for (int i = 0; i < 8; i++) begin
            if (r[(p + i) % 8]) return (p + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_out = 0;
    endtask

    // One clock edge of the arbitration rules.
    task automatic model_step(input logic [7:0] r, input logic [7:0] d);
        int k;
        if (m_busy == 0) begin
            m_out = 0;
            k = scan(r, m_ptr);
            if (k >= 0) begin
                m_busy = 1; m_g = k; m_cnt = 1;
            end
        end else begin
            m_out = int'(d[m_g]);
            if (!r[m_g] || m_cnt == HOLD_MAX) begin
                m_ptr = (m_g + 1) % 8;
                k = scan(r, m_ptr);
                if (k >= 0) begin
                    m_g = k; m_cnt = 1;
                end else begin
                    m_busy = 0; m_out = 0;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] eg;
        eg = (m_busy != 0) ? (8'b1 << m_g) : 8'd0;
        chk_val("gnt",  32'(gnt), 32'(eg));
        chk_val("busy", 32'(busy), 32'(m_busy));
        chk_val("sel",  32'({s0, s1, s2}), 32'(m_g));
        chk_val("out",  32'(out), 32'(m_out));
    endtask

    // Called at a negedge: drive inputs, clock once, check at the next negedge.
    task automatic cyc(input logic [7:0] r, input logic [7:0] d);
        req = r;
        din = d;
        @(posedge clk);
        model_step(r, d);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(input logic [7:0] r, input logic [7:0] d);
        req = r;
        din = d;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk_val("rst_gnt",  32'(gnt), 32'd0);
        chk_val("rst_busy", 32'(busy), 32'd0);
        chk_val("rst_sel",  32'({s0, s1, s2}), 32'd0);
        chk_val("rst_out",  32'(out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        req   = 8'd0;
        din   = 8'd0;
        model_reset();
        @(negedge clk);

        // Reset with everything requesting, then first grant goes to 0.
        do_reset(8'hFF, 8'hFF);
        cyc(8'hFF, 8'hFF);
        chk_val("first_gnt", 32'(gnt), 32'h01);

        // Single requester 3 for two clocks.
        do_reset(8'h00, 8'h00);
        cyc(8'h08, 8'h08);
        chk_val("single_gnt", 32'(gnt), 32'h08);
        chk_val("single_sel", 32'({s0, s1, s2}), 32'd3);
        cyc(8'h08, 8'h08);
        chk_val("single_out", 32'(out), 32'd1);
        cyc(8'h00, 8'h08);
        chk_val("single_rel_gnt",  32'(gnt), 32'h00);
        chk_val("single_rel_busy", 32'(busy), 32'd0);

        // Fairness: all requesting, each owner keeps the mux HOLD_MAX clocks.
        do_reset(8'h00, 8'h00);
        for (int c = 0; c < 36; c++) begin
            cyc(8'hFF, 8'($urandom));
            chk_val("fair_gnt", 32'(gnt), 32'(8'b1 << ((c / HOLD_MAX) % 8)));
        end

        // Wrap: grant 1 then drop it (ptr=2); req 81 picks 7 then 0.
        do_reset(8'h00, 8'h00);
        cyc(8'h02, 8'h00);
        cyc(8'h00, 8'h00);
        cyc(8'h81, 8'h80);
        chk_val("wrap_gnt7", 32'(gnt), 32'h80);
        chk_val("wrap_sel7", 32'({s0, s1, s2}), 32'd7);
        for (int c = 0; c < HOLD_MAX; c++) cyc(8'h81, 8'h80);
        chk_val("wrap_gnt0", 32'(gnt), 32'h01);
        chk_val("wrap_sel0", 32'({s0, s1, s2}), 32'd0);

        // Sole requester times out repeatedly and is re-granted without a gap.
        do_reset(8'h00, 8'h00);
        for (int c = 0; c < 10; c++) begin
            cyc(8'h20, 8'($urandom));
            chk_val("sole_gnt", 32'(gnt), 32'h20);
        end

        // Asynchronous reset in the middle of a grant to 4.
        do_reset(8'h00, 8'h00);
        cyc(8'h10, 8'hFF);
        cyc(8'h10, 8'hFF);
        chk_val("mid_gnt", 32'(gnt), 32'h10);
        do_reset(8'h00, 8'h00);
        cyc(8'hFF, 8'h00);
        chk_val("post_rst_gnt", 32'(gnt), 32'h01);

        // Random traffic: mix of dense and sparse request patterns.
        for (int c = 0; c < 3000; c++) begin
            logic [7:0] r;
            case ($urandom_range(0, 3))
                0:       r = 8'($urandom);
                1:       r = 8'($urandom & $urandom & $urandom);
                2:       r = (gnt != 8'd0 && $urandom_range(0, 1) == 1) ? (req | 8'($urandom & $urandom)) : req;
                default: r = 8'd1 << $urandom_range(0, 7);
            endcase
            if ($urandom_range(0, 499) == 0) do_reset(r, 8'($urandom));
            else cyc(r, 8'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
